// File: rtl/parking_pkg.sv
// Shared types and constants for the parking occupancy control path.
// Holds the gate FSM state encoding, the count width and the default lot size.
package parking_pkg;

    localparam int COUNT_W          = 8;
    localparam int DEFAULT_CAPACITY = 200;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } gate_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge pulse for one
// raw car-loop sensor; the pulse is a single-cycle request to the gate sequencer.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic sensor_i,
    output logic pulse_o
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A sample that agrees with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values,
            // which is what makes the synchronizer a real two-stage chain.
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = level_q & ~prev_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Gate sequencer for the parking lot: serves debounced entry/exit requests one at a
// time, keeps the occupancy count and strobes it into the downstream register.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY         = DEFAULT_CAPACITY,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int GATE_OPEN_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               sensor_entry,
    input  logic               sensor_exit,
    output logic [COUNT_W-1:0] D,
    output logic               en,
    output logic               gate_entry,
    output logic               gate_exit,
    output logic               full,
    output logic               empty,
    output logic               reject
);

    localparam int                 TW         = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
    localparam logic [TW-1:0]      TIMER_LAST = TW'(GATE_OPEN_CYCLES - 1);
    localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);
    localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    gate_state_e        state_q;
    gate_state_e        state_d;
    logic [TW-1:0]      timer_q;
    logic [TW-1:0]      timer_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               en_q;
    logic               en_d;
    logic               reject_q;
    logic               reject_d;
    logic               entry_pend_q;
    logic               entry_pend_d;
    logic               exit_pend_q;
    logic               exit_pend_d;
    logic               gate_entry_q;
    logic               gate_entry_d;
    logic               gate_exit_q;
    logic               gate_exit_d;
    logic               full_q;
    logic               full_d;
    logic               empty_q;
    logic               empty_d;

    logic entry_req;
    logic exit_req;
    logic entry_cand;
    logic exit_cand;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_entry_db (
        .CLK     (CLK),
        .RST     (RST),
        .sensor_i(sensor_entry),
        .pulse_o (entry_req)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit_db (
        .CLK     (CLK),
        .RST     (RST),
        .sensor_i(sensor_exit),
        .pulse_o (exit_req)
    );

    assign entry_cand = entry_req | entry_pend_q;
    assign exit_cand  = exit_req  | exit_pend_q;

    always_comb begin
        // NOTE: every always_comb output is given a default first so that no branch
        // leaves it unassigned and infers a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        count_d      = count_q;
        en_d         = 1'b0;
        reject_d     = 1'b0;
        entry_pend_d = entry_cand;
        exit_pend_d  = exit_cand;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                // Exits win ties so a car leaving frees its space before the next entry.
                if (exit_cand) begin
                    exit_pend_d = 1'b0;
                    if (count_q != '0) begin
                        state_d = EXIT_OPEN;
                    end
                end else if (entry_cand) begin
                    entry_pend_d = 1'b0;
                    if (count_q < CAP_C) begin
                        state_d = ENTRY_OPEN;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ENTRY_OPEN: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    count_d = count_q + COUNT_ONE;
                    en_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            EXIT_OPEN: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    count_d = count_q - COUNT_ONE;
                    en_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        gate_entry_d = (state_d == ENTRY_OPEN);
        gate_exit_d  = (state_d == EXIT_OPEN);
        full_d       = (count_d == CAP_C);
        empty_d      = (count_d == '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            en_q         <= 1'b0;
            reject_q     <= 1'b0;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            gate_entry_q <= 1'b0;
            gate_exit_q  <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            en_q         <= en_d;
            reject_q     <= reject_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            gate_entry_q <= gate_entry_d;
            gate_exit_q  <= gate_exit_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    assign D          = count_q;
    assign en         = en_q;
    assign gate_entry = gate_entry_q;
    assign gate_exit  = gate_exit_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign reject     = reject_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus a randomized run,
// all scored every cycle against a timestamp-style behavioural model of the lot.
module tb_parking_gate_ctrl;

    localparam int CAP  = 2;
    localparam int DEB  = 4;
    localparam int GATE = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       sensor_entry = 1'b0;
    logic       sensor_exit  = 1'b0;
    logic [7:0] D;
    logic       en;
    logic       gate_entry;
    logic       gate_exit;
    logic       full;
    logic       empty;
    logic       reject;

    parking_gate_ctrl #(
        .CAPACITY        (CAP),
        .DEBOUNCE_CYCLES (DEB),
        .GATE_OPEN_CYCLES(GATE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .sensor_entry(sensor_entry),
        .sensor_exit (sensor_exit),
        .D           (D),
        .en          (en),
        .gate_entry  (gate_entry),
        .gate_exit   (gate_exit),
        .full        (full),
        .empty       (empty),
        .reject      (reject)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference model: per sensor a 2-sample delay, a sample history and the accepted
    // level; the lot itself is a count plus "gate open for N more edges" and a direction.
    bit [1:0]  m_pipe [2];
    bit [31:0] m_hist [2];
    int        m_nsamp[2];
    bit        m_lvl  [2];
    bit        m_req  [2];
    bit        m_pend [2];
    int        m_count;
    int        m_gate_left;
    int        m_gate_dir;   // 0 = entry, 1 = exit
    bit        m_en;
    bit        m_rej;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pipe[i]  = '0;
            m_hist[i]  = '0;
            m_nsamp[i] = 0;
            m_lvl[i]   = 1'b0;
            m_req[i]   = 1'b0;
            m_pend[i]  = 1'b0;
        end
        m_count     = 0;
        m_gate_left = 0;
        m_gate_dir  = 0;
        m_en        = 1'b0;
        m_rej       = 1'b0;
    endtask

    task automatic model_edge(input bit raw_entry, input bit raw_exit);
        bit raw[2];
        bit s;
        bit cand_e;
        bit cand_x;
        raw[0] = raw_entry;
        raw[1] = raw_exit;
        m_en   = 1'b0;
        m_rej  = 1'b0;
        if (m_gate_left > 0) begin
            m_pend[0] = m_pend[0] | m_req[0];
            m_pend[1] = m_pend[1] | m_req[1];
            m_gate_left--;
            if (m_gate_left == 0) begin
                m_count = (m_gate_dir == 0) ? m_count + 1 : m_count - 1;
                m_en    = 1'b1;
            end
        end else begin
            cand_e = m_req[0] | m_pend[0];
            cand_x = m_req[1] | m_pend[1];
            if (cand_x) begin
                m_pend[1] = 1'b0;
                m_pend[0] = cand_e;
                if (m_count > 0) begin
                    m_gate_dir  = 1;
                    m_gate_left = GATE;
                end
            end else if (cand_e) begin
                m_pend[0] = 1'b0;
                if (m_count < CAP) begin
                    m_gate_dir  = 0;
                    m_gate_left = GATE;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            s          = m_pipe[i][1];
            m_pipe[i]  = {m_pipe[i][0], raw[i]};
            m_hist[i]  = {m_hist[i][30:0], s};
            m_nsamp[i] = m_nsamp[i] + 1;
            m_req[i]   = 1'b0;
            if (m_nsamp[i] >= DEB && m_hist[i][DEB-1:0] == {DEB{~m_lvl[i]}}) begin
                m_lvl[i]   = ~m_lvl[i];
                m_req[i]   = m_lvl[i];
                m_nsamp[i] = 0;
            end
        end
    endtask

    // One clock: advance the model at the rising edge, score all outputs on the falling edge.
    task automatic step();
        @(posedge CLK);
        edge_no++;
        if (!RST) model_reset();
        else      model_edge(sensor_entry, sensor_exit);
        @(negedge CLK);
        n_checks++;
        if (D !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL cyc%0d D: got %0d want %0d", edge_no, D, m_count);
        end
        n_checks++;
        if (en !== m_en) begin
            n_fail++;
            $display("FAIL cyc%0d en: got %b want %b", edge_no, en, m_en);
        end
        n_checks++;
        if (gate_entry !== (m_gate_left > 0 && m_gate_dir == 0)) begin
            n_fail++;
            $display("FAIL cyc%0d gate_entry: got %b want %b", edge_no, gate_entry,
                     (m_gate_left > 0 && m_gate_dir == 0));
        end
        n_checks++;
        if (gate_exit !== (m_gate_left > 0 && m_gate_dir == 1)) begin
            n_fail++;
            $display("FAIL cyc%0d gate_exit: got %b want %b", edge_no, gate_exit,
                     (m_gate_left > 0 && m_gate_dir == 1));
        end
        n_checks++;
        if (full !== (m_count == CAP)) begin
            n_fail++;
            $display("FAIL cyc%0d full: got %b want %b", edge_no, full, (m_count == CAP));
        end
        n_checks++;
        if (empty !== (m_count == 0)) begin
            n_fail++;
            $display("FAIL cyc%0d empty: got %b want %b", edge_no, empty, (m_count == 0));
        end
        n_checks++;
        if (reject !== m_rej) begin
            n_fail++;
            $display("FAIL cyc%0d reject: got %b want %b", edge_no, reject, m_rej);
        end
    endtask

    // Observation record of one scenario; edges are relative to the first sensor sample.
    int w_ge_first, w_ge_last, w_gx_first, w_en_n, w_rej_n, w_rej_rel;
    int w_en_rel[4];
    int w_en_d[4];
    bit w_en_adj;

    task automatic watch(input bit ent, input bit ext, input int hold, input int ncyc);
        int e0;
        bit prev_en;
        w_ge_first = -1;
        w_ge_last  = -1;
        w_gx_first = -1;
        w_en_n     = 0;
        w_rej_n    = 0;
        w_rej_rel  = -1;
        w_en_adj   = 1'b0;
        prev_en    = 1'b0;
        e0         = edge_no + 1;
        for (int k = 0; k < ncyc; k++) begin
            sensor_entry = (k < hold) ? ent : 1'b0;
            sensor_exit  = (k < hold) ? ext : 1'b0;
            step();
            if (gate_entry === 1'b1) begin
                if (w_ge_first < 0) w_ge_first = edge_no - e0;
                w_ge_last = edge_no - e0;
            end
            if (gate_exit === 1'b1 && w_gx_first < 0) w_gx_first = edge_no - e0;
            if (en === 1'b1) begin
                if (w_en_n < 4) begin
                    w_en_rel[w_en_n] = edge_no - e0;
                    w_en_d[w_en_n]   = int'(D);
                end
                w_en_n++;
                if (prev_en) w_en_adj = 1'b1;
            end
            prev_en = (en === 1'b1);
            if (reject === 1'b1) begin
                w_rej_n++;
                if (w_rej_rel < 0) w_rej_rel = edge_no - e0;
            end
        end
        sensor_entry = 1'b0;
        sensor_exit  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        model_reset();
        repeat (3) step();
        n_checks++;
        if (D !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got D=%0d empty=%b full=%b want D=0 empty=1 full=0", D, empty, full);
        end
        n_checks++;
        if ({en, gate_entry, gate_exit, reject} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000", {en, gate_entry, gate_exit, reject});
        end
        RST = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_glitch();
        watch(1'b1, 1'b0, DEB - 1, 40);
        n_checks++;
        if (w_ge_first != -1 || w_en_n != 0) begin
            n_fail++;
            $display("FAIL glitch_filter: got gate_edge=%0d en_count=%0d want -1 and 0", w_ge_first, w_en_n);
        end
        n_checks++;
        if (D !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_D: got %0d want 0", D);
        end
    endtask

    task automatic test_exit_empty();
        watch(1'b0, 1'b1, 10, 40);
        n_checks++;
        if (w_gx_first != -1 || w_en_n != 0 || w_rej_n != 0) begin
            n_fail++;
            $display("FAIL exit_empty: got gate_edge=%0d en_count=%0d rejects=%0d want -1 0 0",
                     w_gx_first, w_en_n, w_rej_n);
        end
        n_checks++;
        if (D !== 8'd0) begin
            n_fail++;
            $display("FAIL exit_empty_D: got %0d want 0", D);
        end
    endtask

    task automatic test_entry();
        watch(1'b1, 1'b0, 10, 40);
        n_checks++;
        if (w_ge_first != 2 + DEB || w_ge_last != 1 + DEB + GATE) begin
            n_fail++;
            $display("FAIL entry_gate_window: got %0d..%0d want %0d..%0d",
                     w_ge_first, w_ge_last, 2 + DEB, 1 + DEB + GATE);
        end
        n_checks++;
        if (w_en_n != 1 || w_en_rel[0] != 2 + DEB + GATE || w_en_d[0] != 1) begin
            n_fail++;
            $display("FAIL entry_en: got count=%0d edge=%0d D=%0d want 1 %0d 1",
                     w_en_n, w_en_rel[0], w_en_d[0], 2 + DEB + GATE);
        end
        n_checks++;
        if (D !== 8'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL entry_after: got D=%0d empty=%b want D=1 empty=0", D, empty);
        end
    endtask

    task automatic test_simultaneous();
        watch(1'b1, 1'b1, 10, 70);
        n_checks++;
        if (w_gx_first != 2 + DEB || w_ge_first != 3 + DEB + GATE) begin
            n_fail++;
            $display("FAIL simul_order: got exit_edge=%0d entry_edge=%0d want %0d %0d",
                     w_gx_first, w_ge_first, 2 + DEB, 3 + DEB + GATE);
        end
        n_checks++;
        if (w_en_n != 2 || w_en_d[0] != 0 || w_en_d[1] != 1) begin
            n_fail++;
            $display("FAIL simul_en: got count=%0d D0=%0d D1=%0d want 2 0 1", w_en_n, w_en_d[0], w_en_d[1]);
        end
        n_checks++;
        if (w_en_rel[0] != 2 + DEB + GATE || w_en_rel[1] != 3 + DEB + 2 * GATE || w_en_adj) begin
            n_fail++;
            $display("FAIL simul_en_timing: got %0d %0d adj=%b want %0d %0d adj=0",
                     w_en_rel[0], w_en_rel[1], w_en_adj, 2 + DEB + GATE, 3 + DEB + 2 * GATE);
        end
    endtask

    task automatic test_full();
        watch(1'b1, 1'b0, 10, 40);
        n_checks++;
        if (D !== 8'(CAP) || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_reach: got D=%0d full=%b want D=%0d full=1", D, full, CAP);
        end
        watch(1'b1, 1'b0, 10, 40);
        n_checks++;
        if (w_rej_n != 1 || w_rej_rel != 2 + DEB) begin
            n_fail++;
            $display("FAIL full_reject: got count=%0d edge=%0d want 1 %0d", w_rej_n, w_rej_rel, 2 + DEB);
        end
        n_checks++;
        if (w_ge_first != -1 || w_en_n != 0 || D !== 8'(CAP)) begin
            n_fail++;
            $display("FAIL full_hold: got gate_edge=%0d en_count=%0d D=%0d want -1 0 %0d",
                     w_ge_first, w_en_n, D, CAP);
        end
    endtask

    task automatic test_midgate_reset();
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
        for (int k = 0; k < 2 + DEB + 8; k++) begin
            sensor_entry = (k < 10);
            step();
        end
        sensor_entry = 1'b0;
        n_checks++;
        if (gate_entry !== 1'b1) begin
            n_fail++;
            $display("FAIL midgate_open: got %b want 1", gate_entry);
        end
        RST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({gate_entry, en, full, empty} !== 4'b0001 || D !== 8'd0) begin
            n_fail++;
            $display("FAIL midgate_async: got gate=%b en=%b full=%b empty=%b D=%0d want 0 0 0 1 0",
                     gate_entry, en, full, empty, D);
        end
        repeat (2) step();
        RST = 1'b1;
        watch(1'b1, 1'b0, 10, 40);
        n_checks++;
        if (w_ge_first != 2 + DEB || w_en_n != 1 || w_en_rel[0] != 2 + DEB + GATE || w_en_d[0] != 1) begin
            n_fail++;
            $display("FAIL midgate_fresh: got gate_edge=%0d en_count=%0d en_edge=%0d D=%0d want %0d 1 %0d 1",
                     w_ge_first, w_en_n, w_en_rel[0], w_en_d[0], 2 + DEB, 2 + DEB + GATE);
        end
    endtask

    task automatic test_random();
        int hold_e = 0;
        int hold_x = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold_e == 0) begin
                sensor_entry = 1'($urandom_range(0, 1));
                hold_e       = $urandom_range(1, 12);
            end else begin
                hold_e--;
            end
            if (hold_x == 0) begin
                sensor_exit = 1'($urandom_range(0, 1));
                hold_x      = $urandom_range(1, 12);
            end else begin
                hold_x--;
            end
            if ($urandom_range(0, 1499) == 0) begin
                RST = 1'b0;
                #1;
                model_reset();
            end else begin
                RST = 1'b1;
            end
            step();
        end
        RST          = 1'b1;
        sensor_entry = 1'b0;
        sensor_exit  = 1'b0;
        repeat (40) step();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_exit_empty();
        test_entry();
        test_simultaneous();
        test_full();
        test_midgate_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

- Upstream control stage of the occupancy path in the smart parking system.
- Debounces the raw entry and exit car sensors and sequences the two barrier gates.
- Maintains the occupancy count and drives it onto the 8-bit occupancy register's data input, with a one-cycle load enable on every change.
- Also reports full/empty status and rejected entries to the display/alarm logic.

## Interface
Parameters:
- CAPACITY, 200, number of spaces; legal range 1..255.
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a sensor level change; minimum 1.
- GATE_OPEN_CYCLES, 16, cycles a gate stays open per car; minimum 1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- sensor_entry  in  1  raw entry-loop sensor, asynchronous to CLK.
- sensor_exit  in  1  raw exit-loop sensor, asynchronous to CLK.
- D  out  8  occupancy count, equal to the internal count register.
- en  out  1  one-cycle load strobe for the occupancy register.
- gate_entry  out  1  entry barrier open.
- gate_exit  out  1  exit barrier open.
- full  out  1  high when count == CAPACITY.
- empty  out  1  high when count == 0.
- reject  out  1  one-cycle pulse when an entry request is refused because the lot is full.

## Operation
- Reset (RST low, at any time, including mid-gate):
  - State goes to IDLE.
  - count = 0, so D = 0 and empty = 1.
  - en, gate_entry, gate_exit, full, reject = 0.
  - Pending flags, synchronizers and debouncers all clear to 0.
- Sensor path, one instance per sensor:
  - Two-flop synchronizer feeds a debouncer.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any agreeing sample resets the stability counter.
  - A request is a one-cycle pulse on a debounced rising edge.
- Pending flags:
  - There is one pending flag per direction, one deep.
  - A request arriving outside IDLE sets its flag; further requests for that direction while the flag is set are dropped.
  - A flag clears when its request is served or rejected.
- FSM states are IDLE, ENTRY_OPEN and EXIT_OPEN.
  - IDLE, exit candidate (fresh exit pulse or exit pending):
    - if count > 0, go to EXIT_OPEN;
    - if count == 0, drop it silently.
  - IDLE, otherwise, entry candidate (fresh pulse or pending):
    - if count < CAPACITY, go to ENTRY_OPEN;
    - if full, pulse reject for one cycle, drop the request and stay in IDLE.
  - IDLE, simultaneous exit and entry candidates: exit is served first and entry stays pending.
  - ENTRY_OPEN: gate_entry = 1 for exactly GATE_OPEN_CYCLES cycles. On the last cycle's edge: count += 1, en goes high, return to IDLE.
  - EXIT_OPEN: same as ENTRY_OPEN with gate_exit, and count -= 1.
- Arithmetic:
  - count is 8 bits unsigned.
  - Increment is only ever applied when count < CAPACITY and decrement only when count > 0, so no wrap can occur.
  - full and empty are registered compares of count.
- en is high for exactly one cycle after each count change, with D already holding the new value. en is never high in two consecutive cycles.

## Timing
- Request latency:
  - raw sensor sampled high at edge 0;
  - debounced level high after edge 1+DEBOUNCE_CYCLES;
  - gate output high after edge 2+DEBOUNCE_CYCLES (edge 6 by default) when the FSM is in IDLE.
- Gate on the default setting: gate high for 16 cycles, then count/D update and en high in the cycle after the gate drops. The downstream register therefore shows the new value one edge later.
- Back-to-back service: the pending request's gate opens 1 cycle after return to IDLE. This leaves at least one IDLE cycle between gates.
- reject pulse: high in the cycle after the IDLE evaluation edge.
- full and empty update on the same edge as D.

## Structure
Shared package `parking_pkg` holds:
- the state enum (IDLE, ENTRY_OPEN, EXIT_OPEN);
- the 8-bit count width constant;
- the default CAPACITY.

Sub-module `sensor_debounce` contains the synchronizer, debouncer and rising-edge pulse. It is parameterized by DEBOUNCE_CYCLES and instantiated twice.

## Test plan
- Reset, then entry pulse held 10 cycles: gate_entry high edges 6..21; D = 1 and en = 1 for one cycle; the register then reads 1; empty drops.
- Glitch filter: sensor_entry high 3 cycles then low (DEBOUNCE_CYCLES = 4) -> no gate, D stays 0, en never asserts.
- Full lot: with CAPACITY = 2, make two entries, then a third request -> full = 1, a single reject pulse, no gate, D stays 2.
- Simultaneous entry and exit requests with count = 1 -> exit gate first (D = 0); entry served 1 cycle after the return to IDLE (D = 1). en pulses twice, never adjacent.
- Exit with count = 0 -> no gate, no en, no reject, D stays 0.
- RST low mid-ENTRY_OPEN (cycle 8 of 16) -> gate_entry drops immediately; D = 0, en = 0, pending flags cleared. The first request after release behaves exactly as from a fresh reset.
